// File: rtl/sram_ctrl_if.sv
// ----------------------------------------------------------------------------
// sram_ctrl_if
//   Bus-side connection between the b16 bus mux and the SRAM wait-state
//   controller. The master (bus mux) presents one request and holds it stable
//   until it sees the one-cycle ready pulse. The slave (sram_ctrl) returns
//   registered read data along with that pulse.
//
//   Signals
//     sel     master->slave  address decodes to SRAM
//     addr    master->slave  16-bit byte address (SRAM word = addr[15:1])
//     bank    master->slave  upper SRAM address bits from the bank SFR
//     r       master->slave  read request (takes priority over w)
//     w       master->slave  byte write strobes: [1] hi byte, [0] lo byte
//     dwrite  master->slave  write data
//     rdata   slave->master  read data, valid while ready=1 after a read
//     ready   slave->master  one-cycle completion pulse
// ----------------------------------------------------------------------------
interface sram_ctrl_if;
    logic        sel;
    logic [15:0] addr;
    logic [1:0]  bank;
    logic        r;
    logic [1:0]  w;
    logic [15:0] dwrite;
    logic [15:0] rdata;
    logic        ready;

    modport master (
        output sel, addr, bank, r, w, dwrite,
        input  rdata, ready
    );

    modport slave (
        input  sel, addr, bank, r, w, dwrite,
        output rdata, ready
    );
endinterface

// File: rtl/sram_ctrl.sv
// ----------------------------------------------------------------------------
// sram_ctrl
//   Wait-state controller between the b16 bus mux and an external 16-bit
//   asynchronous SRAM. A request is accepted in IDLE, the SRAM strobes are held
//   for a programmable number of ACCESS cycles, and a single DONE cycle raises
//   ready so the top level can let the CPU advance. The SRAM_DQ tristate is
//   built outside this block from dq_o/dq_oe.
//
//   Parameters
//     WAIT_RD  extra ACCESS cycles for reads  (0..15)
//     WAIT_WR  extra ACCESS cycles for writes (0..15)
//
//   Ports
//     clk        system clock, all state changes on posedge
//     nreset     asynchronous active-low reset
//     bus        sram_ctrl_if.slave (sel/addr/bank/r/w/dwrite in, rdata/ready out)
//     sram_addr  {1'b0, bank, addr[15:1]}, combinational
//     dq_i       SRAM_DQ input
//     dq_o       SRAM_DQ output data (always dwrite)
//     dq_oe      drive SRAM_DQ (ACCESS and DONE of a write)
//     ce_n, oe_n, we_n, ub_n, lb_n   SRAM strobes, active low
//
//   Timing: request seen in cycle 0 (IDLE), ACCESS spans cycles 1..WAIT+1,
//   ready is high in cycle WAIT+2, then one IDLE turnaround cycle follows.
// ----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int unsigned WAIT_RD = 1,
    parameter int unsigned WAIT_WR = 2
) (
    input  logic        clk,
    input  logic        nreset,
    sram_ctrl_if.slave  bus,
    output logic [17:0] sram_addr,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe,
    output logic        ce_n,
    output logic        oe_n,
    output logic        we_n,
    output logic        ub_n,
    output logic        lb_n
);

    // The wait counter is 4 bits and never wraps, so larger values cannot be
    // represented; refuse to elaborate rather than silently truncate.
    if (WAIT_RD > 15 || WAIT_WR > 15) begin : g_bad_wait
        $error("sram_ctrl: WAIT_RD and WAIT_WR must be in 0..15");
    end

    localparam logic [3:0] CNT_RD = 4'(WAIT_RD);
    localparam logic [3:0] CNT_WR = 4'(WAIT_WR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        op_rd, op_rd_nxt;   // latched operation: 1 = read, 0 = write
    logic [1:0]  be, be_nxt;         // latched byte enables (11 for reads)
    logic [15:0] rdata_q, rdata_nxt;
    logic        req;
    logic        active;

    // Byte address bit 0 has no meaning for a 16-bit word SRAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = bus.addr[0];

    assign req = bus.sel & (bus.r | (|bus.w));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: rdata is a plain register, not a memory, so it is reset along
    // with the control state and reads back as zero after reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_rd   <= 1'b0;
            be      <= 2'b00;
            rdata_q <= 16'h0000;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_rd   <= op_rd_nxt;
            be      <= be_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_rd_nxt = op_rd;
        be_nxt    = be;
        rdata_nxt = rdata_q;

        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = ACCESS;
                    op_rd_nxt = bus.r;
                    // A read overrides any write strobes and uses both lanes.
                    cnt_nxt   = bus.r ? CNT_RD : CNT_WR;
                    be_nxt    = bus.r ? 2'b11 : bus.w;
                end
            end

            ACCESS: begin
                if (!req) begin
                    // Master gave up: return without a ready pulse and
                    // without touching rdata.
                    state_nxt = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = DONE;
                    if (op_rd) begin
                        rdata_nxt = dq_i;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from registered state only so they are glitch-free
    // relative to the request inputs and follow nreset immediately.
    // ------------------------------------------------------------------------
    assign active    = (state == ACCESS) || (state == DONE);

    assign ce_n      = ~active;
    assign oe_n      = ~(active & op_rd);
    // we_n rises at the start of DONE while dq_oe stays on, giving data hold.
    assign we_n      = ~((state == ACCESS) & ~op_rd);
    assign ub_n      = ~(active & be[1]);
    assign lb_n      = ~(active & be[0]);
    // Driving DQ only on writes keeps dq_oe and oe_n mutually exclusive.
    assign dq_oe     = active & ~op_rd;
    assign dq_o      = bus.dwrite;

    assign sram_addr = {1'b0, bus.bank, bus.addr[15:1]};

    assign bus.ready = (state == DONE);
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_ctrl
//   Self-checking bench for sram_ctrl with WAIT_RD=1, WAIT_WR=2.
//   A table of bus transactions is run back to back; every cycle the strobe
//   vector is compared against a cycle-indexed expectation, and the expected
//   read data/latency is queued at request time and popped on ready.
//   Hand-written sequences cover reset, abort and reset mid-access.
// ----------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int WAIT_RD = 1;
    localparam int WAIT_WR = 2;

    // {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, ready}
    localparam logic [6:0] PINS_IDLE = 7'b1111100;

    logic        clk;
    logic        nreset;
    logic [17:0] sram_addr;
    logic [15:0] dq_i;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;

    sram_ctrl_if bus_if ();

    sram_ctrl #(
        .WAIT_RD (WAIT_RD),
        .WAIT_WR (WAIT_WR)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus_if),
        .sram_addr (sram_addr),
        .dq_i      (dq_i),
        .dq_o      (dq_o),
        .dq_oe     (dq_oe),
        .ce_n      (ce_n),
        .oe_n      (oe_n),
        .we_n      (we_n),
        .ub_n      (ub_n),
        .lb_n      (lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          r;
        logic [1:0]  w;
        logic [15:0] addr;
        logic [1:0]  bank;
        logic [15:0] dwrite;
        logic [15:0] dq;
        logic [17:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_rdata;
    int          checks;
    int          failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic [6:0] pins_now();
        return {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, bus_if.ready};
    endfunction

    // Expected strobes for a transaction in a given phase: 0 IDLE, 1 ACCESS, 2 DONE.
    function automatic logic [6:0] exp_pins(input bit rd, input logic [1:0] w, input int phase);
        logic [6:0] p;
        p = PINS_IDLE;
        if (phase == 1) p = rd ? 7'b0010000 : {3'b010, ~w[1], ~w[0], 2'b10};
        if (phase == 2) p = rd ? 7'b0010001 : {3'b011, ~w[1], ~w[0], 2'b11};
        return p;
    endfunction

    task automatic idle_bus();
        bus_if.sel    = 1'b0;
        bus_if.r      = 1'b0;
        bus_if.w      = 2'b00;
    endtask

    // Runs one transaction starting just after a posedge (cycle 0) and
    // returns just after the edge that closes DONE, with the request dropped.
    task automatic run_vec(input int idx, input vec_t v);
        int         wt;
        int         phase;
        exp_t       e;
        logic [6:0] pins;
        wt = v.r ? WAIT_RD : WAIT_WR;

        bus_if.sel    = 1'b1;
        bus_if.r      = v.r;
        bus_if.w      = v.w;
        bus_if.addr   = v.addr;
        bus_if.bank   = v.bank;
        bus_if.dwrite = v.dwrite;
        dq_i          = v.dq;
        if (v.r) model_rdata = v.dq;
        sb_q.push_back('{rdata: model_rdata, lat: wt + 2});

        for (int c = 0; c <= wt + 2; c++) begin
            @(negedge clk);
            phase = (c == 0) ? 0 : (c <= wt + 1) ? 1 : 2;
            pins  = pins_now();
            check($sformatf("v%0d.c%0d.pins", idx, c), 32'(pins), 32'(exp_pins(v.r, v.w, phase)));
            check($sformatf("v%0d.c%0d.oe_vs_dq_oe", idx, c), 32'(dq_oe & ~oe_n), 32'd0);
            if (c == 1) begin
                check($sformatf("v%0d.sram_addr", idx), 32'(sram_addr), 32'(v.exp_addr));
                check($sformatf("v%0d.dq_o", idx), 32'(dq_o), 32'(v.dwrite));
            end
            if (bus_if.ready) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d.unexpected_ready", idx), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("v%0d.rdata", idx), 32'(bus_if.rdata), 32'(e.rdata));
                    check($sformatf("v%0d.latency", idx), 32'(c), 32'(e.lat));
                end
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("v%0d.ready_seen", idx), 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        idle_bus();
    endtask

    vec_t vecs[6];

    initial begin
        checks      = 0;
        failures    = 0;
        model_rdata = 16'h0000;

        vecs[0] = '{r: 1'b1, w: 2'b00, addr: 16'h4002, bank: 2'd0, dwrite: 16'h0000, dq: 16'hBEEF, exp_addr: 18'h02001};
        vecs[1] = '{r: 1'b0, w: 2'b10, addr: 16'h4002, bank: 2'd0, dwrite: 16'h12AB, dq: 16'hDEAD, exp_addr: 18'h02001};
        vecs[2] = '{r: 1'b0, w: 2'b01, addr: 16'h8004, bank: 2'd2, dwrite: 16'h00CD, dq: 16'h7777, exp_addr: 18'h14002};
        vecs[3] = '{r: 1'b1, w: 2'b11, addr: 16'hFFFE, bank: 2'd3, dwrite: 16'hFFFF, dq: 16'h1234, exp_addr: 18'h1FFFF};
        vecs[4] = '{r: 1'b0, w: 2'b11, addr: 16'h0000, bank: 2'd1, dwrite: 16'hA55A, dq: 16'h0000, exp_addr: 18'h08000};
        vecs[5] = '{r: 1'b1, w: 2'b00, addr: 16'h2468, bank: 2'd2, dwrite: 16'h0000, dq: 16'hC3C3, exp_addr: 18'h11234};

        nreset        = 1'b0;
        dq_i          = 16'h0000;
        bus_if.addr   = 16'h0000;
        bus_if.bank   = 2'd0;
        bus_if.dwrite = 16'h0000;
        idle_bus();

        // Reset state
        #2;
        check("reset.pins", 32'(pins_now()), 32'(PINS_IDLE));
        check("reset.rdata", 32'(bus_if.rdata), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Table: back-to-back transactions, one IDLE turnaround between each
        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Abort: drop sel in cycle 2 of a write
        bus_if.sel    = 1'b1;
        bus_if.w      = 2'b01;
        bus_if.addr   = 16'h1234;
        bus_if.dwrite = 16'h5555;
        @(negedge clk);
        check("abort.c0", 32'(pins_now()), 32'(PINS_IDLE));
        @(posedge clk); #1;
        @(negedge clk);
        check("abort.c1", 32'(pins_now()), 32'(exp_pins(1'b0, 2'b01, 1)));
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        check("abort.c2", 32'(pins_now()), 32'(exp_pins(1'b0, 2'b01, 1)));
        @(posedge clk); #1;
        for (int c = 3; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("abort.c%0d.pins", c), 32'(pins_now()), 32'(PINS_IDLE));
            check($sformatf("abort.c%0d.rdata", c), 32'(bus_if.rdata), 32'(model_rdata));
            @(posedge clk); #1;
        end

        // Reset in the middle of a read ACCESS
        bus_if.sel  = 1'b1;
        bus_if.r    = 1'b1;
        bus_if.addr = 16'h0010;
        bus_if.bank = 2'd1;
        dq_i        = 16'hA5A5;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid.access", 32'(pins_now()), 32'(exp_pins(1'b1, 2'b00, 1)));
        #1;
        nreset = 1'b0;
        #1;
        check("rst_mid.pins_async", 32'(pins_now()), 32'(PINS_IDLE));
        check("rst_mid.rdata_async", 32'(bus_if.rdata), 32'd0);
        model_rdata = 16'h0000;
        idle_bus();
        @(posedge clk); #1;
        check("rst_mid.held", 32'(pins_now()), 32'(PINS_IDLE));
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        run_vec(6, '{r: 1'b1, w: 2'b00, addr: 16'h0010, bank: 2'd1, dwrite: 16'h0000, dq: 16'h0F0F, exp_addr: 18'h08008});
        run_vec(7, '{r: 1'b0, w: 2'b11, addr: 16'h0010, bank: 2'd1, dwrite: 16'h6789, dq: 16'h0000, exp_addr: 18'h08008});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
